param_datamem: RTL
==================

PARAM_DATAMEM -- requirements
Module: param_datamem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the word width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the address width; depth is 2**ADDR_W words and legal values are 1..12.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit, access request strobe.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read; meaningful only with en=1.
REQ-007 The block SHALL have port be, input, DATA_W/8 bits, byte-lane write enables; bit k covers din[8k+7:8k].
REQ-008 The block SHALL have port addr, input, ADDR_W bits, word address.
REQ-009 The block SHALL have port din, input, DATA_W bits, write data.
REQ-010 The block SHALL have port clr, input, 1 bit, synchronous request to re-zero the whole memory.
REQ-011 The block SHALL have port dout, output, DATA_W bits, registered read data.
REQ-012 The block SHALL have port dout_valid, output, 1 bit, one-cycle pulse marking new dout.
REQ-013 The block SHALL have port ready, output, 1 bit: 1 = requests accepted, 0 = initialisation in progress.

Function
REQ-014 The controller SHALL have two states, INIT and READY; ready SHALL be 1 exactly in READY.
REQ-015 In INIT, the controller SHALL write all-zero to the word at the init counter each cycle, starting at 0 and incrementing by 1.
REQ-016 After writing word 2**ADDR_W-1, the controller SHALL move to READY on the following edge; a full sweep takes 2**ADDR_W cycles and the counter SHALL not wrap.
REQ-017 A request SHALL be accepted only when en=1, ready=1 and clr=0; any other request SHALL be ignored, with no memory change and no dout_valid.
REQ-018 An accepted write SHALL update only the byte lanes with be[k]=1; be all-zero SHALL be accepted and change nothing.
REQ-019 A write SHALL never assert dout_valid or change dout.
REQ-020 An accepted read SHALL load dout with mem[addr] at the accepting edge and assert dout_valid for exactly the next cycle (latency 1).
REQ-021 Reads accepted on consecutive cycles SHALL produce consecutive dout_valid pulses, one per cycle, with no bubbles.
REQ-022 dout SHALL hold its last read value until the next accepted read.
REQ-023 A read accepted on the cycle after a write to the same address SHALL return the newly written data, including lanes that write left unchanged.
REQ-024 clr=1 in READY SHALL move the controller to INIT with the counter set to 0 on the next edge.
REQ-025 clr=1 during INIT SHALL restart the counter at 0.
REQ-026 If clr=1 and en=1 in the same cycle, clr SHALL win and the request SHALL be dropped.
REQ-027 A read accepted on the edge before clr takes effect SHALL still deliver its dout_valid pulse.
REQ-028 dout SHALL NOT be cleared by clr.

Reset
REQ-029 While rst=1, regardless of clk: state = INIT, counter = 0, ready = 0, dout = 0, dout_valid = 0.
REQ-030 Asserting rst mid-operation SHALL immediately drop any pending dout_valid and abort any sweep.
REQ-031 Memory contents SHALL NOT be reset asynchronously; zeroing comes only from the INIT sweep that starts at the first edge after rst deasserts.
REQ-032 After rst deasserts, ready SHALL go to 1 after exactly 2**ADDR_W rising edges.

Verification
REQ-033 Release rst, DATA_W=16, ADDR_W=4 -> ready=0 for 16 cycles, then 1; a read of each of addr 0..15 returns 0x0000 with one dout_valid per read.
REQ-034 Write addr 3 din=0xA55A be=11, then write addr 3 din=0x1234 be=01, then read addr 3 -> dout=0xA534 with dout_valid one cycle after the read.
REQ-035 Back-to-back reads of addr 1,2,3 holding 0x0011,0x0022,0x0033 -> dout_valid high 3 consecutive cycles, dout = 0x0011, 0x0022, 0x0033.
REQ-036 en=1 we=1 during INIT, and en=1 with clr=1 in READY -> no memory change (later reads return 0x0000) and no dout_valid.
REQ-037 clr pulsed in READY after writing 0xFFFF to addr 7 -> ready=0 for 16 cycles; a later read of addr 7 returns 0x0000; dout kept its prior value throughout.
REQ-038 rst asserted between a read's accepting edge and its valid cycle -> dout_valid=0 and dout=0 at once, with no valid pulse after release.

Source files
------------

// File: rtl/param_datamem.sv
// Parameterised word-addressed data memory with byte-lane writes, registered
// reads and a self-clearing INIT sweep after reset or on a clr request.
//
// state | meaning
// INIT  | sweeping zeros into mem[cnt], requests ignored, ready=0
// READY | accepting read/write requests, ready=1
module param_datamem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic                clr,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                ready
);

  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, READY} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc, wr, rd, last;

  assign ready = (state == READY);
  assign acc   = en & ready & ~clr;
  assign wr    = acc & we;
  assign rd    = acc & ~we;
  assign last  = (cnt == {ADDR_W{1'b1}});

  always_comb begin
    state_n = state;
    case (state)
      INIT:    if (!clr && last) state_n = READY;
      READY:   if (clr) state_n = INIT;
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (clr)
        cnt <= '0;
      else if (state == INIT && !last)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd;
      if (rd) dout <= mem[addr];
    end
  end

  // Storage has no reset; held rst also suppresses the sweep so zeroing
  // begins only on the first edge after release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (wr) begin
        for (int k = 0; k < LANES; k++)
          if (be[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
      end
    end
  end

endmodule
